fsm_evt_gate: RTL and testbench

- Parametrised Mealy-style sequence controller for the FSM benchmark suite, with registered outputs.
- Counts "activation" events (RUN->HOLD transitions).
- Once the count reaches a threshold, gates the output codes of transitions leaving selected states.
- Successor to the fixed-width, single-gated-state controllers: widths, threshold and the gated-state set are parameters, and gating is compile-time selectable.

---
 rtl/fsm_evt_gate.sv | 80 ++++++++
 tb/tb_fsm_evt_gate.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fsm_evt_gate.sv
// fsm_evt_gate: activation-counting sequence controller with registered one-cycle transition codes.
// Output gating of masked source states is compiled in only when FSM_EVT_GATE_EN is defined.
module fsm_evt_gate #(
    parameter int         IN_W        = 13,
    parameter int         OUT_W       = 20,
    parameter int         CNT_W       = 4,
    parameter int         THRESH      = 5,
    parameter int         HOLD_CYC    = 3,
    parameter logic [4:0] MASK_STATES = 5'b00100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] y,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             gated_o
);
    typedef enum logic [2:0] {IDLE = 3'd0, ARM = 3'd1, RUN = 3'd2, HOLD = 3'd3, DONE = 3'd4} state_t;
    localparam int              TW      = $clog2(HOLD_CYC + 1);
    localparam logic [7:0]      MASK    = {3'b000, MASK_STATES};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t           state, state_n;
    logic [TW-1:0]    tmr, tmr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [OUT_W-1:0] y_n;
    logic             take, flag;
    assign flag    = in_valid & x[IN_W-1];
    assign state_o = state;
    assign cnt_o   = cnt;
`ifdef FSM_EVT_GATE_EN
    assign gated_o = cnt >= CNT_W'(THRESH);
`else
    assign gated_o = 1'b0;
`endif
    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        cnt_n   = cnt;
        case (state)
            IDLE: if (in_valid && x[0]) state_n = ARM;
            ARM: begin
                if (in_valid && x[1]) state_n = RUN;
                else if (in_valid && x[2]) state_n = IDLE;
            end
            RUN: begin
                if (in_valid && x[3]) begin
                    state_n = HOLD;
                    tmr_n   = '0;
                    cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                end else if (in_valid && x[2]) state_n = IDLE;
            end
            HOLD: begin
                if (in_valid && x[2]) state_n = IDLE;
                else if (tmr == TW'(HOLD_CYC - 1)) state_n = DONE;
                else tmr_n = tmr + 1'b1;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // illegal encodings recover to IDLE silently, so they never count as a transition
        take = (state_n != state) && (state <= DONE);
        y_n  = (take && !(gated_o && MASK[state]))
             ? ((OUT_W'(1) << state_n) | {flag, {(OUT_W-1){1'b0}}}) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
            cnt   <= '0;
            y     <= '0;
        end else begin
            state <= state_n;
            tmr   <= tmr_n;
            cnt   <= cnt_n;
            y     <= y_n;
        end
    end
endmodule

// File: tb/tb_fsm_evt_gate.sv
// tb_fsm_evt_gate: vector table plus scoreboard for the default instance, and a narrow-counter
// instance for saturation and flag coverage; expected gating follows FSM_EVT_GATE_EN.
module tb_fsm_evt_gate;
    logic        clk = 1'b0;
    logic        rst, in_valid, rst_b, in_valid_b;
    logic [12:0] x, x_b;
    logic [19:0] y, y_b;
    logic [2:0]  state_o, state_b;
    logic [3:0]  cnt_o;
    logic [1:0]  cnt_b;
    logic        gated_o, gated_b;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic        r, v;
        logic [12:0] x;
        logic [19:0] y;
        logic [2:0]  s;
        logic [3:0]  c;
    } vec_t;
    typedef struct {
        logic [19:0] y;
        logic [2:0]  s;
        logic [3:0]  c;
        logic        g;
    } exp_t;
    vec_t tbl [32];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fsm_evt_gate dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
        .y(y), .state_o(state_o), .cnt_o(cnt_o), .gated_o(gated_o)
    );
    fsm_evt_gate #(.CNT_W(2), .THRESH(3)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .x(x_b),
        .y(y_b), .state_o(state_b), .cnt_o(cnt_b), .gated_o(gated_b)
    );

    function automatic logic gate_exp(input int c, input int th);
`ifdef FSM_EVT_GATE_EN
        return c >= th;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [12:0] xx,
                        input logic [19:0] ey, input logic [2:0] es, input logic [3:0] ec, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = v; x = xx;
        exp_q.push_back('{ey, es, ec, gate_exp(int'(ec), 5)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".y"}, 32'(y), 32'(e.y));
        chk({tag, ".state"}, 32'(state_o), 32'(e.s));
        chk({tag, ".cnt"}, 32'(cnt_o), 32'(e.c));
        chk({tag, ".gated"}, 32'(gated_o), 32'(e.g));
    endtask

    task automatic run_cycle(input int k);
        string t;
        t = $sformatf("cyc%0d", k);
        step(0, 1, 13'h0001, 20'h00002, 3'd1, 4'(k - 1), {t, ".arm"});
        step(0, 1, 13'h0002, 20'h00004, 3'd2, 4'(k - 1), {t, ".run"});
        step(0, 1, 13'h0008, gate_exp(k - 1, 5) ? 20'h0 : 20'h00008, 3'd3, 4'(k), {t, ".hold"});
        step(0, 0, 13'h0000, 20'h00000, 3'd3, 4'(k), {t, ".h1"});
        step(0, 0, 13'h0000, 20'h00000, 3'd3, 4'(k), {t, ".h2"});
        step(0, 0, 13'h0000, 20'h00010, 3'd4, 4'(k), {t, ".done"});
        step(0, 0, 13'h0000, 20'h00001, 3'd0, 4'(k), {t, ".idle"});
    endtask

    task automatic step_b(input logic r, input logic v, input logic [12:0] xx,
                          input logic [19:0] ey, input logic [2:0] es, input int ec, input string tag);
        @(negedge clk);
        rst_b = r; in_valid_b = v; x_b = xx;
        @(posedge clk);
        #1;
        chk({tag, ".y"}, 32'(y_b), 32'(ey));
        chk({tag, ".state"}, 32'(state_b), 32'(es));
        chk({tag, ".cnt"}, 32'(cnt_b), 32'(ec));
        chk({tag, ".gated"}, 32'(gated_b), 32'(gate_exp(ec, 3)));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = '0;
        rst_b = 1'b1; in_valid_b = 1'b0; x_b = '0;
        tbl = '{
            '{1, 0, 13'h0000, 20'h00000, 3'd0, 4'd0},
            '{0, 1, 13'h0001, 20'h00002, 3'd1, 4'd0},
            '{0, 1, 13'h0002, 20'h00004, 3'd2, 4'd0},
            '{0, 1, 13'h0008, 20'h00008, 3'd3, 4'd1},
            '{0, 0, 13'h0000, 20'h00000, 3'd3, 4'd1},
            '{1, 0, 13'h0000, 20'h00000, 3'd0, 4'd0},
            '{0, 0, 13'h0001, 20'h00000, 3'd0, 4'd0},
            '{0, 1, 13'h0001, 20'h00002, 3'd1, 4'd0},
            '{0, 1, 13'h0002, 20'h00004, 3'd2, 4'd0},
            '{0, 1, 13'h0008, 20'h00008, 3'd3, 4'd1},
            '{0, 0, 13'h0000, 20'h00000, 3'd3, 4'd1},
            '{0, 1, 13'h0000, 20'h00000, 3'd3, 4'd1},
            '{0, 0, 13'h0000, 20'h00010, 3'd4, 4'd1},
            '{0, 0, 13'h0000, 20'h00001, 3'd0, 4'd1},
            '{0, 1, 13'h0001, 20'h00002, 3'd1, 4'd1},
            '{0, 1, 13'h0000, 20'h00000, 3'd1, 4'd1},
            '{0, 1, 13'h0006, 20'h00004, 3'd2, 4'd1},
            '{0, 0, 13'h0008, 20'h00000, 3'd2, 4'd1},
            '{0, 1, 13'h000C, 20'h00008, 3'd3, 4'd2},
            '{0, 1, 13'h0004, 20'h00001, 3'd0, 4'd2},
            '{0, 1, 13'h0001, 20'h00002, 3'd1, 4'd2},
            '{0, 1, 13'h0004, 20'h00001, 3'd0, 4'd2},
            '{0, 1, 13'h0001, 20'h00002, 3'd1, 4'd2},
            '{0, 1, 13'h0002, 20'h00004, 3'd2, 4'd2},
            '{0, 1, 13'h0004, 20'h00001, 3'd0, 4'd2},
            '{0, 1, 13'h1001, 20'h80002, 3'd1, 4'd2},
            '{0, 1, 13'h0002, 20'h00004, 3'd2, 4'd2},
            '{0, 1, 13'h0008, 20'h00008, 3'd3, 4'd3},
            '{0, 0, 13'h0000, 20'h00000, 3'd3, 4'd3},
            '{0, 0, 13'h0000, 20'h00000, 3'd3, 4'd3},
            '{0, 0, 13'h0000, 20'h00010, 3'd4, 4'd3},
            '{0, 0, 13'h0000, 20'h00001, 3'd0, 4'd3}
        };
        for (int i = 0; i < 32; i++)
            step(tbl[i].r, tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].s, tbl[i].c, $sformatf("vec%0d", i));
        // counts 4..6: the transition reaching 5 is ungated, the next RUN->HOLD is masked when enabled
        for (int k = 4; k <= 6; k++) run_cycle(k);
        step_b(1, 0, 13'h0000, 20'h00000, 3'd0, 0, "b.rst");
        for (int i = 1; i <= 5; i++) begin
            step_b(0, 1, 13'h1001, 20'h80002, 3'd1, (i - 1 > 3) ? 3 : i - 1, $sformatf("b%0d.arm", i));
            step_b(0, 1, 13'h0002, 20'h00004, 3'd2, (i - 1 > 3) ? 3 : i - 1, $sformatf("b%0d.run", i));
            step_b(0, 1, 13'h0008, gate_exp((i - 1 > 3) ? 3 : i - 1, 3) ? 20'h0 : 20'h00008, 3'd3,
                   (i > 3) ? 3 : i, $sformatf("b%0d.hold", i));
            step_b(0, 1, 13'h0004, 20'h00001, 3'd0, (i > 3) ? 3 : i, $sformatf("b%0d.abort", i));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
